// File: rtl/spi_rx.sv
// SPI slave receiver: oversamples cs/sclk/mosi in the clk domain and delivers one
// DATA_W-bit word per frame on a valid/ready port. Optional: SPI_RX_GLITCH_FILTER_EN.
module spi_rx #(
  parameter int DATA_W     = 12,
  parameter int LEAD_EDGES = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int LW = (LEAD_EDGES > 0) ? $clog2(LEAD_EDGES + 1) : 1;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LEAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;

  // {cs, sclk, mosi} synchroniser; lvl/hist carry only {cs, sclk}
  logic [2:0] s1, s2;
  logic [1:0] lvl, hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      hist <= '1;
    end else begin
      s1   <= {cs, sclk, mosi};
      s2   <= s1;
      hist <= lvl;
    end
  end

`ifdef SPI_RX_GLITCH_FILTER_EN
  // A level is accepted only once two consecutive s2 samples agree.
  localparam logic [2:0] SETTLE = 3'd5;
  logic [1:0] fprev, filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fprev <= '1;
      filt  <= '1;
    end else begin
      fprev <= s2[2:1];
      filt  <= (s2[2:1] & ~(s2[2:1] ^ fprev)) | (filt & (s2[2:1] ^ fprev));
    end
  end

  assign lvl = filt;
`else
  localparam logic [2:0] SETTLE = 3'd3;
  assign lvl = s2[2:1];
`endif

  logic cs_fall, cs_rise, sclk_fall, mosi_s;
  assign cs_fall   =  hist[1] & ~lvl[1];
  assign cs_rise   = ~hist[1] &  lvl[1];
  assign sclk_fall =  hist[0] & ~lvl[0];
  assign mosi_s    =  s2[0];

  logic [2:0]        state;
  logic [2:0]        settle;
  logic [LW-1:0]     lead_cnt, lead_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg;
  logic              in_frame, done;

  assign lead_nxt = lead_cnt + LW'(1);
  assign bit_nxt  = bit_cnt + BW'(1);
  assign in_frame = (state == S_LEAD) || (state == S_SHIFT) || (state == S_TRAIL);
  assign done     = (state == S_TRAIL) && cs_rise;

  // Synchroniser levels right after reset are fake idle values, so WAIT
  // lets the pipeline flush before trusting cs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      settle    <= '0;
      lead_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (in_frame && cs_rise) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        frame_err <= (state != S_TRAIL);
      end else begin
        case (state)
          S_WAIT: begin
            if (settle != SETTLE) settle <= settle + 3'd1;
            else if (lvl[1])      state  <= S_IDLE;
          end
          S_IDLE: begin
            if (cs_fall) begin
              busy     <= 1'b1;
              lead_cnt <= '0;
              bit_cnt  <= '0;
              state    <= (LEAD_EDGES == 0) ? S_SHIFT : S_LEAD;
            end
          end
          S_LEAD: begin
            if (sclk_fall) begin
              lead_cnt <= lead_nxt;
              if (lead_nxt == LW'(LEAD_EDGES)) begin
                bit_cnt <= '0;
                state   <= S_SHIFT;
              end
            end
          end
          S_SHIFT: begin
            if (sclk_fall) begin
              // Shifting lands bit k at position k (or DATA_W-1-k) once all bits are in.
              if (LSB_FIRST != 0) shreg <= {mosi_s, shreg[DATA_W-1:1]};
              else                shreg <= {shreg[DATA_W-2:0], mosi_s};
              bit_cnt <= bit_nxt;
              if (bit_nxt == BW'(DATA_W)) state <= S_TRAIL;
            end
          end
          S_TRAIL: ;
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI slave receiver and the downstream stage of the team's 12-bit SPI transmitter.
- Takes cs, sclk and mosi from the transmitter's pins, oversamples them in the fast system clock domain and deserialises one DATA_W-bit word per frame.
- Presents each word on a valid/ready parallel interface, with frame-error and overrun flags.
- sclk must be slow relative to clk; the transmitter runs sclk at about 1/22 of clk.

Parameters:
- DATA_W, 12: bits captured per frame.
- LEAD_EDGES, 1: sclk falling edges discarded after cs falls, before the first data bit.
- LSB_FIRST, 1: 1 = first captured bit goes to rx_data[0]; 0 = first captured bit goes to rx_data[DATA_W-1].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- sclk  input  1  serial clock from the transmitter; asynchronous to clk.
- cs  input  1  chip select, active low; asynchronous.
- mosi  input  1  serial data; asynchronous.
- rx_data  output  DATA_W  received word; valid while rx_valid=1.
- rx_valid  output  1  word available.
- rx_ready  input  1  consumer accepts the word when rx_valid and rx_ready are both 1 at a clk edge.
- busy  output  1  frame in progress.
- frame_err  output  1  one-cycle pulse: frame ended with fewer than DATA_W bits.
- overrun  output  1  one-cycle pulse: completed word dropped.

Behaviour:
- Synchronisation: cs, sclk and mosi each pass through 2 flops (s1, s2) plus a history flop (s3).
  - Edge events are decoded from s2 versus s3.
  - An event acts at the 3rd clk edge, counting the edge that first samples the new pin level.
  - All outputs are registered.
- Reset (rst_n=0 at a clk edge): rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, sync flops=1 (idle levels), counters=0, state=WAIT_IDLE.
- States:
  - WAIT_IDLE: go to IDLE once synced cs=1. A frame already in progress at reset release is ignored entirely.
  - IDLE: on cs fall, go to LEAD (lead_cnt=0), or straight to SHIFT if LEAD_EDGES=0. sclk activity while cs=1 is ignored.
  - LEAD: each sclk fall increments lead_cnt. When lead_cnt reaches LEAD_EDGES, go to SHIFT (bit_cnt=0).
  - SHIFT: each sclk fall samples synced mosi into shift bit position bit_cnt (per LSB_FIRST), then bit_cnt++. After DATA_W bits, go to TRAIL.
  - TRAIL: further sclk falls are ignored. This covers the transmitter's trailing 0 bit.
- Counter widths: bit_cnt is clog2(DATA_W+1) bits and never wraps.
- busy=1 in LEAD, SHIFT and TRAIL.
- Frame end (cs rise, any of LEAD/SHIFT/TRAIL → IDLE):
  - From TRAIL: frame complete.
  - Otherwise: frame_err=1 for one cycle; shift register discarded; rx_valid unaffected.
- cs rise and sclk fall decoded in the same clk cycle: cs rise wins and the sclk edge is ignored.
- cs fall while in IDLE with LEAD_EDGES=0 and an sclk fall in the same cycle: the sclk edge is ignored.
- Output holding register (single entry):
  - Complete frame and rx_valid=0: load rx_data, rx_valid=1.
  - Complete frame, rx_valid=1 and rx_ready=1 in the same cycle: load the new word, rx_valid stays 1, no overrun.
  - Complete frame, rx_valid=1 and rx_ready=0: new word dropped, overrun=1 for one cycle, held word unchanged.
  - rx_valid clears on handshake when no new word is loaded in that cycle.
  - rx_data is stable while rx_valid=1 and not accepted.
- Transmitter framing: with default parameters, the transmitter's 14 sclk falls per cs-low window map to 1 lead edge, 12 data bits and 1 trailing edge.

Optional Feature:
- Macro: SPI_RX_GLITCH_FILTER_EN.
- Defined:
  - sclk and cs each pass through a 2-sample majority/stability filter after s2.
  - A level change is accepted only after it has been stable for 2 consecutive clk cycles.
  - Event latency becomes 5 clk edges.
  - Single-cycle pulses on sclk or cs are never seen.
- Undefined: no filter; latency is 3 edges as above. The mosi path is unchanged in both cases.

Test Plan:
- Transmitter frame with din=12'hA5C, sclk half-period 11 clk, rx_ready=1: rx_valid pulses 1 cycle with rx_data=12'hA5C, no frame_err, busy high for the cs-low window only.
- LSB_FIRST=0, serial bits 1,0,0,0,0,0,0,0,0,0,0,1 after 1 lead edge: rx_data=12'h801.
- cs low, 1 lead edge plus 5 data edges, then cs high: frame_err pulses 1 cycle, rx_valid stays 0, busy drops.
- rx_ready=0, two back-to-back frames 12'h123 then 12'h456: rx_data holds 12'h123, overrun pulses once after the second frame; rx_ready=1 then clears rx_valid.
- rst_n=0 for 2 cycles mid-frame, released while cs is still low: no rx_valid and no frame_err for that frame; next full frame 12'hFFF is received correctly.
- With SPI_RX_GLITCH_FILTER_EN: 1-clk sclk low glitches during SHIFT do not advance bit_cnt; frame 12'h3C3 is received intact. Without the macro, the same stimulus yields a wrong word.
